flight_subframe_assembler: RTL

//  Parametrised successor of the fixed subframe former. On each frame tick it reads SRC_WORDS
//  16-bit parametric words from the FDAU register RAM, packs them in pairs with a sync/sequence

---
 rtl/flight_frame_pkg.sv | 18 +
 rtl/subframe_pingpong_ram.sv | 24 ++
 rtl/flight_subframe_assembler.sv | 117 +++++++++++
 3 files changed

// File: rtl/flight_frame_pkg.sv
// flight_frame_pkg: shared FSM states, sync words and CRC-16/CCITT step for the subframe assembler
package flight_frame_pkg;
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, READ, CRC, DONE} state_t;
  localparam logic [15:0] SYNC [16] = '{
    16'h0247, 16'h05B8, 16'h0A47, 16'h0DB8,
    16'h0247, 16'h05B8, 16'h0A47, 16'h0DB8,
    16'h0247, 16'h05B8, 16'h0A47, 16'h0DB8,
    16'h0247, 16'h05B8, 16'h0A47, 16'h0DB8
  };
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [31:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 31; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? CRC_POLY : 16'h0000);
    return r;
  endfunction
endpackage

// File: rtl/subframe_pingpong_ram.sv
// subframe_pingpong_ram: two-bank entry buffer, writes go to one bank while the other is read
module subframe_pingpong_ram
  import flight_frame_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          toggle,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [31:0]   wd,
  input  logic [AW-1:0] ra,
  output logic [31:0]   rd
);
  logic [31:0] mem [2**(AW+1)];
  logic bank;
  // bank is the write bank; the read port always uses the other one
  always_ff @(posedge clock) bank <= reset ? 1'b0 : bank ^ toggle;
  // write port into the bank under construction
  always_ff @(posedge clock) if (we) mem[{bank, wa}] <= wd;
  // registered read from the completed bank
  always_ff @(posedge clock) rd <= reset ? 32'h0 : mem[{~bank, ra}];
endmodule

// File: rtl/flight_subframe_assembler.sv
// flight_subframe_assembler: packs source RAM words into headed ping-pong subframes; FRAME_CRC_EN appends a CRC entry
module flight_subframe_assembler
  import flight_frame_pkg::*;
#(
  parameter int          SRC_WORDS = 64,
  parameter int          SRC_AW    = 9,
  parameter int          OUT_AW    = 8,
  parameter int          SUBFRAMES = 4,
  parameter logic [31:0] SERIAL    = 32'h52503234
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  output logic [SRC_AW-1:0] rd_adau,
  input  logic [15:0]       q_adau,
  input  logic [OUT_AW-1:0] rd_FLIGHT,
  output logic [31:0]       FLIGHT_out,
  output logic              frame_rdy,
  output logic [3:0]        frame_cnt,
  output logic              busy,
  output logic              overrun
);
  localparam int CW = $clog2(SRC_WORDS + 1);
`ifdef FRAME_CRC_EN
  localparam state_t LAST = CRC;
  logic [15:0] crc;
`else
  localparam state_t LAST = DONE;
`endif
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [15:0] hold;
  logic [3:0] sf_idx;
  logic [11:0] seq;
  logic we, swap, wrap;
  logic [OUT_AW-1:0] wa;
  logic [31:0] wd;
  assign busy = state != IDLE;
  assign swap = state == DONE;
  assign wrap = sf_idx == 4'(SUBFRAMES - 1);
  assign rd_adau = (state == READ && cnt < CW'(SRC_WORDS)) ? SRC_AW'(cnt) : '0;
  // state register
  always_ff @(posedge clock) state <= reset ? IDLE : next;
  // next state and entry write; source data for word k sits on q_adau while cnt == k+1
  always_comb begin
    next = state;
    we = 1'b0;
    wa = '0;
    wd = '0;
    case (state)
      IDLE: next = tick ? HDR0 : IDLE;
      HDR0: begin
        next = HDR1;
        we = 1'b1;
        wd = {SYNC[sf_idx], seq, sf_idx};
      end
      HDR1: begin
        next = READ;
        we = 1'b1;
        wa = OUT_AW'(1);
        wd = SERIAL;
      end
      READ: begin
        next = cnt == CW'(SRC_WORDS) ? LAST : READ;
        we = cnt != '0 && !cnt[0];
        wa = OUT_AW'(cnt >> 1) + OUT_AW'(1);
        wd = {hold, q_adau};
      end
`ifdef FRAME_CRC_EN
      CRC: begin
        next = DONE;
        we = 1'b1;
        wa = OUT_AW'(SRC_WORDS / 2 + 2);
        wd = {16'h0000, crc};
      end
`endif
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end
  // counters, even-word hold, subframe bookkeeping and status pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      hold <= '0;
      sf_idx <= '0;
      seq <= '0;
      frame_rdy <= 1'b0;
      frame_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      cnt <= state == READ ? cnt + CW'(1) : '0;
      if (state == READ && cnt[0]) hold <= q_adau;
      frame_rdy <= swap;
      overrun <= tick && busy;
      if (swap) begin
        frame_cnt <= sf_idx;
        sf_idx <= wrap ? 4'h0 : sf_idx + 4'h1;
        seq <= seq + 12'(wrap);
      end
    end
  end
`ifdef FRAME_CRC_EN
  // running CRC over every entry written this subframe, restarted while idle
  always_ff @(posedge clock) crc <= (reset || state == IDLE) ? CRC_INIT : we ? crc16_step(crc, wd) : crc;
`endif
  subframe_pingpong_ram #(.AW(OUT_AW)) u_ram (
    .clock (clock),
    .reset (reset),
    .toggle(swap),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .ra    (rd_FLIGHT),
    .rd    (FLIGHT_out)
  );
endmodule
